// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter
//   Shares one OBI-style program-memory port between the instruction-fetch
//   channel (IF) and the load/store unit (LS). A request that is presented
//   but not granted is locked so the memory port stays stable until
//   mem_gnt. The source of every granted request is queued, and in-order
//   responses are steered back to the requester that issued them.
//
// Parameters
//   MAX_OUTSTANDING : max accepted-but-unanswered transactions (1..8)
//   ARB_MODE        : 0 = round-robin, 1 = fixed priority (LS always wins)
//
// Ports
//   clk, reset_n                     : clock, async active-low reset
//   instr_req/addr/gnt               : IF request channel (read only)
//   instr_rdata/err/valid            : IF response channel
//   data_req/we/be/addr/wdata/gnt    : LS request channel
//   data_rdata/err/valid             : LS response channel
//   mem_req/we/be/addr/wdata, mem_gnt: memory request channel
//   mem_rdata/err/valid              : memory response channel (in order)
//   rsp_orphan                       : sticky, response seen with nothing outstanding
module imem_port_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned ARB_MODE        = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        instr_req,
  input  logic [31:0] instr_addr,
  output logic        instr_gnt,
  output logic [31:0] instr_rdata,
  output logic        instr_err,
  output logic        instr_valid,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [3:0]  data_be,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_gnt,
  output logic [31:0] data_rdata,
  output logic        data_err,
  output logic        data_valid,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic [31:0] mem_rdata,
  input  logic        mem_err,
  input  logic        mem_valid,
  output logic        rsp_orphan
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

  typedef enum logic {
    SRC_IF = 1'b0,
    SRC_LS = 1'b1
  } src_e;

  logic [CNT_W-1:0] count_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  src_e             id_fifo_q [MAX_OUTSTANDING];
  logic             lock_q;
  src_e             locked_id_q;
  src_e             last_winner_q;
  logic             orphan_q;

  src_e             winner;
  logic             winner_req;
  logic             any_req;
  logic             can_issue;
  logic             push;
  logic             pop;
  src_e             head;

  // ---------------- selection ----------------
  always_comb begin
    winner = SRC_IF;
    if (lock_q) begin
      winner = locked_id_q;
    end else if (instr_req && data_req) begin
      if (ARB_MODE == 1) begin
        winner = SRC_LS;
      end else if (last_winner_q == SRC_IF) begin
        winner = SRC_LS;
      end else begin
        winner = SRC_IF;
      end
    end else if (data_req) begin
      winner = SRC_LS;
    end
  end

  assign winner_req = (winner == SRC_LS) ? data_req : instr_req;
  assign any_req    = instr_req | data_req;

  // A response pops the ID FIFO in the same cycle, so it frees a slot for
  // a grant even when the FIFO is full.
  assign can_issue  = (count_q < CNT_MAX) | mem_valid;

  // reset_n gating keeps grants quiet while reset is held, even though the
  // request path itself is combinational.
  assign mem_req    = reset_n & can_issue & any_req;

  // ---------------- request mux ----------------
  always_comb begin
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (mem_req) begin
      if (winner == SRC_LS) begin
        mem_we    = data_we;
        mem_be    = data_be;
        mem_addr  = data_addr;
        mem_wdata = data_wdata;
      end else begin
        mem_we    = 1'b0;
        mem_be    = '1;
        mem_addr  = instr_addr;
        mem_wdata = '0;
      end
    end
  end

  assign push      = mem_req & mem_gnt;
  assign instr_gnt = push & (winner == SRC_IF);
  assign data_gnt  = push & (winner == SRC_LS);

  // ---------------- response steering ----------------
  assign pop         = mem_valid & (count_q != '0);
  assign head        = id_fifo_q[rd_ptr_q];
  assign instr_valid = pop & (head == SRC_IF);
  assign data_valid  = pop & (head == SRC_LS);
  assign instr_rdata = mem_rdata;
  assign data_rdata  = mem_rdata;
  assign instr_err   = mem_err;
  assign data_err    = mem_err;
  assign rsp_orphan  = orphan_q;

  // ---------------- state ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
        id_fifo_q[i] <= SRC_IF;
      end
    end else begin
      if (push) begin
        id_fifo_q[wr_ptr_q] <= winner;
        wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // A locked requester that drops its request releases the lock before the
  // stall check, so the next cycle performs a fresh selection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_q        <= 1'b0;
      locked_id_q   <= SRC_IF;
      last_winner_q <= SRC_IF;
      orphan_q      <= 1'b0;
    end else begin
      if (lock_q && !winner_req) begin
        lock_q <= 1'b0;
      end else if (mem_req && !mem_gnt) begin
        lock_q      <= 1'b1;
        locked_id_q <= winner;
      end else if (mem_gnt) begin
        lock_q <= 1'b0;
      end
      if (push) begin
        last_winner_q <= winner;
      end
      if (mem_valid && (count_q == '0)) begin
        orphan_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb_imem_port_arbiter
//   Directed bench for imem_port_arbiter (MAX_OUTSTANDING=2, round-robin).
//   Inputs are driven 1 ns after the rising edge, outputs sampled on the
//   falling edge.
module tb_imem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic        instr_gnt;
  logic [31:0] instr_rdata;
  logic        instr_err;
  logic        instr_valid;
  logic        data_req;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_gnt;
  logic [31:0] data_rdata;
  logic        data_err;
  logic        data_valid;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic [31:0] mem_rdata;
  logic        mem_err;
  logic        mem_valid;
  logic        rsp_orphan;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  imem_port_arbiter #(
    .MAX_OUTSTANDING(2),
    .ARB_MODE       (0)
  ) u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .instr_req  (instr_req),
    .instr_addr (instr_addr),
    .instr_gnt  (instr_gnt),
    .instr_rdata(instr_rdata),
    .instr_err  (instr_err),
    .instr_valid(instr_valid),
    .data_req   (data_req),
    .data_we    (data_we),
    .data_be    (data_be),
    .data_addr  (data_addr),
    .data_wdata (data_wdata),
    .data_gnt   (data_gnt),
    .data_rdata (data_rdata),
    .data_err   (data_err),
    .data_valid (data_valid),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rdata  (mem_rdata),
    .mem_err    (mem_err),
    .mem_valid  (mem_valid),
    .rsp_orphan (rsp_orphan)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    instr_req  = 1'b0;
    instr_addr = '0;
    data_req   = 1'b0;
    data_we    = 1'b0;
    data_be    = 4'hf;
    data_addr  = '0;
    data_wdata = '0;
    mem_gnt    = 1'b0;
    mem_rdata  = '0;
    mem_err    = 1'b0;
    mem_valid  = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_gnts(input string tag, input logic ig, input logic dg);
    check({tag, "_instr_gnt"}, 32'(instr_gnt), 32'(ig));
    check({tag, "_data_gnt"},  32'(data_gnt),  32'(dg));
  endtask

  task automatic check_valids(input string tag, input logic iv, input logic dv);
    check({tag, "_instr_valid"}, 32'(instr_valid), 32'(iv));
    check({tag, "_data_valid"},  32'(data_valid),  32'(dv));
  endtask

  initial begin
    idle();
    reset_n = 1'b0;

    // ---- reset state ----
    @(negedge clk);
    check("rst_mem_req", 32'(mem_req), 0);
    check_gnts("rst", 1'b0, 1'b0);
    check_valids("rst", 1'b0, 1'b0);
    check("rst_orphan", 32'(rsp_orphan), 0);
    next_cycle();
    reset_n = 1'b1;
    next_cycle();

    // ---- 1: IF-only stream ----
    instr_req = 1'b1; instr_addr = 32'h100; mem_gnt = 1'b1;
    data_wdata = 32'h12345678;
    @(negedge clk);
    check("t1a_mem_req", 32'(mem_req), 1);
    check("t1a_addr", mem_addr, 32'h100);
    check("t1a_be", 32'(mem_be), 32'hf);
    check("t1a_we", 32'(mem_we), 0);
    check("t1a_wdata", mem_wdata, 0);
    check_gnts("t1a", 1'b1, 1'b0);
    check_valids("t1a", 1'b0, 1'b0);
    next_cycle();
    instr_addr = 32'h104; mem_valid = 1'b1; mem_rdata = 32'haaaa0001;
    @(negedge clk);
    check("t1b_addr", mem_addr, 32'h104);
    check_gnts("t1b", 1'b1, 1'b0);
    check_valids("t1b", 1'b1, 1'b0);
    check("t1b_rdata", instr_rdata, 32'haaaa0001);
    next_cycle();
    instr_req = 1'b0; mem_gnt = 1'b0; mem_rdata = 32'haaaa0002;
    @(negedge clk);
    check("t1c_mem_req", 32'(mem_req), 0);
    check_valids("t1c", 1'b1, 1'b0);
    check("t1c_rdata", instr_rdata, 32'haaaa0002);
    next_cycle();
    idle();
    next_cycle();

    // ---- 2: both request every cycle; last winner was IF so LS goes first ----
    for (int i = 0; i < 4; i++) begin
      instr_req = 1'b1; instr_addr = 32'h200;
      data_req  = 1'b1; data_addr  = 32'h300;
      mem_gnt   = 1'b1;
      mem_valid = (i > 0);
      mem_rdata = 32'h5000 + 32'(i);
      @(negedge clk);
      check_gnts($sformatf("t2_%0d", i), (i % 2) == 1, (i % 2) == 0);
      check($sformatf("t2_%0d_addr", i), mem_addr, ((i % 2) == 0) ? 32'h300 : 32'h200);
      check_valids($sformatf("t2_%0d", i), (i > 0) && ((i % 2) == 0), (i % 2) == 1);
      next_cycle();
    end
    idle();
    mem_valid = 1'b1; mem_rdata = 32'h5004;
    @(negedge clk);
    check_valids("t2_tail", 1'b1, 1'b0);
    next_cycle();
    idle();
    next_cycle();

    // ---- 3: stall locks the winner even when the other side joins ----
    instr_req = 1'b1; instr_addr = 32'h400;
    @(negedge clk);
    check("t3_0_addr", mem_addr, 32'h400);
    check_gnts("t3_0", 1'b0, 1'b0);
    next_cycle();
    data_req = 1'b1; data_addr = 32'h300;
    for (int i = 1; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("t3_%0d_addr", i), mem_addr, 32'h400);
      check_gnts($sformatf("t3_%0d", i), 1'b0, 1'b0);
      next_cycle();
    end
    mem_gnt = 1'b1;
    @(negedge clk);
    check("t3_gnt_addr", mem_addr, 32'h400);
    check_gnts("t3_gnt", 1'b1, 1'b0);
    next_cycle();

    // ---- 4: capacity, FIFO holds IF; LS grant fills it ----
    @(negedge clk);
    check("t4_ls_addr", mem_addr, 32'h300);
    check_gnts("t4_ls", 1'b0, 1'b1);
    next_cycle();
    @(negedge clk);
    check("t4_full_mem_req", 32'(mem_req), 0);
    check_gnts("t4_full", 1'b0, 1'b0);
    next_cycle();
    mem_valid = 1'b1; mem_rdata = 32'h7777;
    @(negedge clk);
    check("t4_pop_mem_req", 32'(mem_req), 1);
    check("t4_pop_addr", mem_addr, 32'h400);
    check_gnts("t4_pop", 1'b1, 1'b0);
    check_valids("t4_pop", 1'b1, 1'b0);
    next_cycle();
    mem_valid = 1'b0;
    @(negedge clk);
    check("t4_still_full", 32'(mem_req), 0);
    next_cycle();
    idle();
    mem_valid = 1'b1;
    @(negedge clk);
    check_valids("t4_rsp_ls", 1'b0, 1'b1);
    next_cycle();
    @(negedge clk);
    check_valids("t4_rsp_if", 1'b1, 1'b0);
    next_cycle();
    idle();
    next_cycle();

    // ---- 5: LS write and error response ----
    data_req = 1'b1; data_we = 1'b1; data_be = 4'h3;
    data_addr = 32'h500; data_wdata = 32'hdeadbeef; mem_gnt = 1'b1;
    @(negedge clk);
    check("t5_we", 32'(mem_we), 1);
    check("t5_be", 32'(mem_be), 32'h3);
    check("t5_wdata", mem_wdata, 32'hdeadbeef);
    check("t5_addr", mem_addr, 32'h500);
    check_gnts("t5", 1'b0, 1'b1);
    next_cycle();
    idle();
    mem_valid = 1'b1; mem_err = 1'b1;
    @(negedge clk);
    check_valids("t5_rsp", 1'b0, 1'b1);
    check("t5_err", 32'(data_err), 1);
    next_cycle();
    idle();
    next_cycle();

    // ---- 6: orphan response and mid-burst reset ----
    mem_valid = 1'b1;
    @(negedge clk);
    check_valids("t6_orph", 1'b0, 1'b0);
    check("t6_orph_pre", 32'(rsp_orphan), 0);
    next_cycle();
    idle();
    @(negedge clk);
    check("t6_orph_set", 32'(rsp_orphan), 1);
    next_cycle();
    @(negedge clk);
    check("t6_orph_sticky", 32'(rsp_orphan), 1);
    next_cycle();
    instr_req = 1'b1; instr_addr = 32'h600; mem_gnt = 1'b1;
    @(negedge clk);
    check_gnts("t6_burst", 1'b1, 1'b0);
    next_cycle();
    reset_n = 1'b0; mem_valid = 1'b1;
    #2;
    check_gnts("t6_rst", 1'b0, 1'b0);
    check_valids("t6_rst", 1'b0, 1'b0);
    check("t6_rst_mem_req", 32'(mem_req), 0);
    check("t6_rst_orphan", 32'(rsp_orphan), 0);
    next_cycle();
    reset_n = 1'b1;
    idle();
    mem_valid = 1'b1;
    @(negedge clk);
    check_valids("t6_post", 1'b0, 1'b0);
    next_cycle();
    idle();
    @(negedge clk);
    check("t6_post_orphan", 32'(rsp_orphan), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
